xcore_iter_shifter: RTL and testbench

- Multi-cycle bidirectional shift unit for the Xcore ALU.
- Each cycle it performs one single-bit shift step across the whole word. A column of per-bit 4-input selects (left neighbour, right neighbour, sign/zero fill, hold) picks each bit's next value, and a cycle counter steps the word until the requested amount is reached.
- It sits between the execute-stage operand issue and the ALU result writeback, with valid/ready handshakes on both sides.

---
 rtl/xcore_iter_shifter.sv | 136 +++++++++++++
 tb/tb_xcore_iter_shifter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/xcore_iter_shifter.sv
// Iterative bidirectional shifter: one single-bit step per cycle until the registered
// shift amount is consumed, with valid/ready handshakes on operand and result sides.
module xcore_iter_shifter #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic             in_dir,
    input  logic             in_arith,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    // Handshake: a transfer happens on any rising edge where valid && ready are both high;
    // a producer holds its bundle stable until that edge, the unit never drops ready early.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SEL_HOLD  = 2'd0,
        SEL_LOWER = 2'd1,
        SEL_UPPER = 2'd2,
        SEL_FILL  = 2'd3
    } sel_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] step_word;
    logic [SHW-1:0]   count_q;
    logic             dir_q;
    logic             arith_q;
    logic             accept;
    logic             step;
    logic             fill_bit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        step    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = (in_shamt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                step = 1'b1;
                if (count_q == SHW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Only a right arithmetic shift brings in ones; left and logical shifts fill with zero.
    assign fill_bit = arith_q & ~dir_q & data_q[WIDTH-1];

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        localparam int LO = (i == 0) ? 0 : i - 1;
        localparam int HI = (i == WIDTH - 1) ? WIDTH - 1 : i + 1;
        sel_t sel;
        logic nxt;

        always_comb begin
            sel = SEL_HOLD;
            if (step) begin
                if (dir_q) begin
                    sel = (i == 0) ? SEL_FILL : SEL_LOWER;
                end else begin
                    sel = (i == WIDTH - 1) ? SEL_FILL : SEL_UPPER;
                end
            end
        end

        always_comb begin
            nxt = data_q[i];
            unique case (sel)
                SEL_HOLD:  nxt = data_q[i];
                SEL_LOWER: nxt = data_q[LO];
                SEL_UPPER: nxt = data_q[HI];
                SEL_FILL:  nxt = fill_bit;
                default:   nxt = data_q[i];
            endcase
        end

        assign step_word[i] = nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            count_q <= '0;
            dir_q   <= 1'b0;
            arith_q <= 1'b0;
        end else if (accept) begin
            data_q  <= in_data;
            count_q <= in_shamt;
            dir_q   <= in_dir;
            arith_q <= in_arith;
        end else if (step) begin
            data_q  <= step_word;
            count_q <= count_q - SHW'(1);
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign out_data  = data_q;

endmodule

// File: tb/tb_xcore_iter_shifter.sv
// Bench for xcore_iter_shifter: directed vector table, multi-cycle corner sequences
// and a randomized regression scored against a plain-arithmetic shift model.
module tb_xcore_iter_shifter;

    localparam int W  = 32;
    localparam int SW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [SW-1:0] in_shamt;
    logic          in_dir;
    logic          in_arith;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          busy;

    int n_checks = 0;
    int n_pass   = 0;
    logic [W-1:0] exp_q[$];

    typedef struct {
        logic [W-1:0] data;
        int           shamt;
        logic         dir;
        logic         arith;
        logic [W-1:0] exp;
    } vec_t;

    vec_t vecs[10];

    xcore_iter_shifter #(.WIDTH(W), .SHW(SW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_dir    (in_dir),
        .in_arith  (in_arith),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d, input int sh,
                                               input logic dir, input logic ar);
        logic signed [W-1:0] s;
        s = d;
        if (dir) return d << sh;
        if (ar) return s >>> sh;
        return d >> sh;
    endfunction

    // Drive one op, scramble the inputs after accept, then score latency, busy, hold and data.
    task automatic run_op(input logic [W-1:0] d, input int sh, input logic dir, input logic ar,
                          input logic [W-1:0] expv, input int stall, input string tag);
        int lat;
        int t;
        logic [W-1:0] held;
        logic busy_ok;
        logic hold_ok;
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = d;
        in_shamt  = SW'(sh);
        in_dir    = dir;
        in_arith  = ar;
        out_ready = 1'b0;
        t = 0;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        exp_q.push_back(expv);
        in_valid = 1'b0;
        in_data  = $urandom;
        in_shamt = SW'($urandom_range(0, W - 1));
        in_dir   = 1'($urandom_range(0, 1));
        in_arith = 1'($urandom_range(0, 1));
        busy_ok = 1'b1;
        lat = 1;
        while (!out_valid && lat < 100) begin
            if (!busy) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (!busy) busy_ok = 1'b0;
        check({tag, "_latency"}, W'(lat), W'(sh + 1));
        check({tag, "_busy"}, W'(busy_ok), W'(1));
        held = out_data;
        hold_ok = 1'b1;
        repeat (stall) begin
            @(negedge clk);
            if (!out_valid || out_data !== held) hold_ok = 1'b0;
        end
        if (stall > 0) check({tag, "_hold"}, W'(hold_ok), W'(1));
        out_ready = 1'b1;
        if (exp_q.size() > 0) check({tag, "_data"}, out_data, exp_q.pop_front());
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        int t;
        logic blocked_ok;
        logic [W-1:0] d;
        int sh;
        logic dir;
        logic ar;

        vecs[0] = '{32'h0000_0001, 4,  1'b1, 1'b0, 32'h0000_0010};
        vecs[1] = '{32'h8000_0000, 31, 1'b0, 1'b1, 32'hFFFF_FFFF};
        vecs[2] = '{32'h8000_0000, 31, 1'b0, 1'b0, 32'h0000_0001};
        vecs[3] = '{32'hDEAD_BEEF, 0,  1'b0, 1'b0, 32'hDEAD_BEEF};
        vecs[4] = '{32'h4000_0000, 1,  1'b1, 1'b1, 32'h8000_0000};
        vecs[5] = '{32'h0000_00F0, 4,  1'b0, 1'b0, 32'h0000_000F};
        vecs[6] = '{32'h0000_0001, 31, 1'b1, 1'b0, 32'h8000_0000};
        vecs[7] = '{32'hF000_0000, 4,  1'b0, 1'b1, 32'hFF00_0000};
        vecs[8] = '{32'h7FFF_FFFF, 31, 1'b0, 1'b1, 32'h0000_0000};
        vecs[9] = '{32'h1234_5678, 8,  1'b1, 1'b0, 32'h3456_7800};

        // Reset
        in_valid  = 1'b0;
        in_data   = '0;
        in_shamt  = '0;
        in_dir    = 1'b0;
        in_arith  = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_in_ready", W'(in_ready), W'(1));
        check("reset_out_valid", W'(out_valid), W'(0));
        check("reset_busy", W'(busy), W'(0));
        check("reset_out_data", out_data, '0);

        // Directed vector table
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].data, vecs[i].shamt, vecs[i].dir, vecs[i].arith, vecs[i].exp,
                   (i % 3), $sformatf("vec%0d", i));
        end

        // Backpressure with a competing bundle held on the input while busy
        @(negedge clk);
        in_valid = 1'b1; in_data = 32'h0000_00F0; in_shamt = 5'd4; in_dir = 1'b0; in_arith = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        in_data = 32'h0000_0003; in_shamt = 5'd2; in_dir = 1'b1; in_arith = 1'b0;
        blocked_ok = 1'b1;
        t = 0;
        while (!out_valid && t < 100) begin
            if (in_ready) blocked_ok = 1'b0;
            @(negedge clk);
            t++;
        end
        check("bp_latency", W'(t), W'(4));
        repeat (3) begin
            if (in_ready) blocked_ok = 1'b0;
            check("bp_out_valid", W'(out_valid), W'(1));
            check("bp_out_data", out_data, 32'h0000_000F);
            @(negedge clk);
        end
        check("bp_blocked", W'(blocked_ok), W'(1));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_ready_after_hs", W'(in_ready), W'(1));
        check("bp_valid_after_hs", W'(out_valid), W'(0));
        @(negedge clk);
        in_valid = 1'b0;
        t = 0;
        while (!out_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("bp2_latency", W'(t), W'(2));
        check("bp2_data", out_data, 32'h0000_000C);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Reset while shifting, with three steps left
        in_valid = 1'b1; in_data = 32'h0000_0001; in_shamt = 5'd10; in_dir = 1'b1; in_arith = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        check("mid_busy_before", W'(busy), W'(1));
        #1 rst = 1'b1;
        #1;
        check("mid_rst_out_valid", W'(out_valid), W'(0));
        check("mid_rst_out_data", out_data, '0);
        check("mid_rst_busy", W'(busy), W'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", W'(in_ready), W'(1));
        check("post_rst_out_valid", W'(out_valid), W'(0));
        run_op(32'h0000_0001, 1, 1'b1, 1'b0, 32'h0000_0002, 0, "post_rst");

        // Randomized regression against the reference model
        for (int n = 0; n < 1000; n++) begin
            d   = $urandom;
            sh  = $urandom_range(0, W - 1);
            dir = 1'($urandom_range(0, 1));
            ar  = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_op(d, sh, dir, ar, ref_shift(d, sh, dir, ar), $urandom_range(0, 3),
                   $sformatf("rand%0d", n));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
